alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_core.sv | 42 ++++
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and opcode-class helpers for the sequential ALU.
package alu_seq_pkg;

  // Single-cycle opcodes (OP[3] = 0), same encodings as the legacy combinational ALU
  localparam logic [3:0] OP_BUS = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AC  = 4'd6;
  localparam logic [3:0] OP_NEG = 4'd7;

  // Multi-cycle opcodes; 12..15 are reserved and complete in one cycle with a zero result
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op[3] && op[2];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Sequencer-to-ALU handshake and data bundle. WIDTH must match the alu_seq instance.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic             ld_ac;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             c;
  logic             z;
  logic             busy;
  logic             done;

  // Sequencer side
  modport master (
    output start, op, ld_ac, bus,
    input  ac, result, result_hi, c, z, busy, done
  );

  // ALU side
  modport slave (
    input  start, op, ld_ac, bus,
    output ac, result, result_hi, c, z, busy, done
  );
endinterface

// File: rtl/alu_seq_core.sv
// Combinational single-cycle datapath: OP[2:0], AC, BUS -> result and carry.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cy
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Select the legacy ALU function and its carry
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    y  = '0;
    cy = 1'b0;
    case ({1'b0, op})
      OP_BUS: y = b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_ADD: {cy, y} = sum;
      OP_SUB: begin
        y  = a - b;
        cy = (a >= b);
      end
      OP_AC:  y = a;
      OP_NEG: begin
        y  = {WIDTH{1'b0}} - a;
        cy = (a != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: accumulator, C/Z flags, iterative shifts and shift-add multiply.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_if.slave    io
);

  // Counter must hold WIDTH for the multiply as well as any shift amount
  localparam int CW = SHW + 1;

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic               ld_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH-1:0]   ac_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               c_q;
  logic               z_q;
  logic               done_q;

  logic [SHW-1:0]     n;
  logic [WIDTH-1:0]   core_y;
  logic               core_c;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  logic               wb_en;
  logic               wb_ld;
  logic [WIDTH-1:0]   wb_res;
  logic [WIDTH-1:0]   wb_hi;
  logic               wb_c;

  assign n = io.bus[SHW-1:0];

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op (io.op[2:0]),
    .a  (io.ac),
    .b  (io.bus),
    .y  (core_y),
    .cy (core_c)
  );

  // One shift step on the captured operand; the bit leaving the word becomes the carry
  always_comb begin
    sh_next = sh_q;
    sh_out  = 1'b0;
    case (op_q)
      OP_SHL:  {sh_out, sh_next} = {sh_q, 1'b0};
      OP_SHR:  {sh_next, sh_out} = {1'b0, sh_q};
      OP_SAR:  {sh_next, sh_out} = {sh_q[WIDTH-1], sh_q};
      default: ;
    endcase
  end

  // One shift-add step: multiplier sits in the low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Decide whether this edge completes an op and what it writes back
  always_comb begin
    wb_en  = 1'b0;
    wb_ld  = ld_q;
    wb_res = '0;
    wb_hi  = '0;
    wb_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        wb_ld = io.ld_ac;
        if (io.start) begin
          if (!io.op[3]) begin
            wb_en  = 1'b1;
            wb_res = core_y;
            wb_c   = core_c;
          end else if (is_reserved(io.op)) begin
            wb_en = 1'b1;
          end else if (is_shift(io.op) && (n == '0)) begin
            wb_en  = 1'b1;
            wb_res = io.ac;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt == CW'(1)) begin
          wb_en  = 1'b1;
          wb_res = sh_next;
          wb_c   = sh_out;
        end
      end
      ST_MUL: begin
        if (cnt == CW'(1)) begin
          wb_en  = 1'b1;
          wb_res = acc_next[WIDTH-1:0];
          wb_hi  = acc_next[2*WIDTH-1:WIDTH];
          wb_c   = (acc_next[2*WIDTH-1:WIDTH] != '0);
        end
      end
      default: ;
    endcase
  end

  // FSM and multi-cycle engine; operands are captured only on acceptance in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      ld_q    <= 1'b0;
      cnt     <= '0;
      sh_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (io.start) begin
            op_q    <= io.op;
            ld_q    <= io.ld_ac;
            sh_q    <= io.ac;
            mcand_q <= io.ac;
            acc_q   <= {{WIDTH{1'b0}}, io.bus};
            if (io.op == OP_MUL) begin
              cnt   <= CW'(WIDTH);
              state <= ST_MUL;
            end else if (is_shift(io.op) && (n != '0)) begin
              cnt   <= {1'b0, n};
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          sh_q <= sh_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_IDLE;
        end
        ST_MUL: begin
          acc_q <= acc_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Architectural registers: result, flags, accumulator and the DONE pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= wb_en;
      if (wb_en) begin
        result_q    <= wb_res;
        result_hi_q <= wb_hi;
        c_q         <= wb_c;
        z_q         <= (wb_res == '0);
        if (wb_ld) ac_q <= wb_res;
      end
    end
  end

  assign io.ac        = ac_q;
  assign io.result    = result_q;
  assign io.result_hi = result_hi_q;
  assign io.c         = c_q;
  assign io.z         = z_q;
  assign io.busy      = (state != ST_IDLE);
  assign io.done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [15:0] ac;
    logic        c;
    logic        z;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8;
  exp_t e16;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .io(if8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .io(if16));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every DONE pulse against the oldest expected response
  always @(negedge clk) begin
    if (if8.done) begin
      if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("w8_result",    if8.result,    e8.res);
        check("w8_result_hi", if8.result_hi, e8.hi);
        check("w8_ac",        if8.ac,        e8.ac);
        check("w8_c",         if8.c,         e8.c);
        check("w8_z",         if8.z,         e8.z);
        check("w8_latency",   cyc,           e8.due);
      end
    end
    if (if16.done) begin
      if (q16.size() == 0) check("w16_unexpected_done", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("w16_result",    if16.result,    e16.res);
        check("w16_result_hi", if16.result_hi, e16.hi);
        check("w16_ac",        if16.ac,        e16.ac);
        check("w16_c",         if16.c,         e16.c);
        check("w16_z",         if16.z,         e16.z);
        check("w16_latency",   cyc,            e16.due);
      end
    end
  end

  task automatic drive(input bit w16, input logic s, input logic [3:0] op,
                       input logic [15:0] bus, input logic ld);
    if (w16) begin
      if16.start = s; if16.op = op; if16.bus = bus; if16.ld_ac = ld;
    end else begin
      if8.start = s; if8.op = op; if8.bus = bus[7:0]; if8.ld_ac = ld;
    end
  endtask

  // Issue one op at a negedge, queue its expected response, wait for DONE (bounded).
  // With poke set, START (op 0, BUS 0, LD_AC 1) is held high during BUSY and must be ignored.
  task automatic issue(input bit w16, input logic [3:0] op, input logic [15:0] bus,
                       input logic ld, input logic [15:0] er, input logic [15:0] eh,
                       input logic [15:0] eac, input logic ec, input int lat, input bit poke);
    exp_t e;
    int   busy_n;
    bit   seen;
    e.res = er; e.hi = eh; e.ac = eac; e.c = ec; e.z = (er == 16'h0);
    e.due = cyc + lat;
    if (w16) q16.push_back(e); else q8.push_back(e);
    drive(w16, 1'b1, op, bus, ld);
    @(negedge clk);
    if (w16) if16.start = 1'b0; else if8.start = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (w16 ? if16.done : if8.done) begin
        seen = 1'b1;
        break;
      end
      if (w16 ? if16.busy : if8.busy) busy_n++;
      if (poke) drive(w16, 1'b1, OP_BUS, 16'h0000, 1'b1);
      @(negedge clk);
      if (w16) if16.start = 1'b0; else if8.start = 1'b0;
    end
    check(w16 ? "w16_busy_cycles" : "w8_busy_cycles", busy_n, lat - 1);
    if (!seen) check(w16 ? "w16_done_timeout" : "w8_done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ac",     if8.ac,        0);
    check("rst_result", if8.result,    0);
    check("rst_hi",     if8.result_hi, 0);
    check("rst_c",      if8.c,         0);
    check("rst_z",      if8.z,         1);
    check("rst_busy",   if8.busy,      0);
    check("rst_done",   if8.done,      0);

    // Single-cycle ops:     op       bus    ld  res    hi  ac     c  lat poke
    issue(0, OP_BUS, 16'hF0, 1, 16'hF0, 0, 16'hF0, 0, 1, 0);
    issue(0, OP_ADD, 16'h20, 1, 16'h10, 0, 16'h10, 1, 1, 0);
    issue(0, OP_SUB, 16'h10, 0, 16'h00, 0, 16'h10, 1, 1, 0);
    issue(0, OP_BUS, 16'h05, 1, 16'h05, 0, 16'h05, 0, 1, 0);
    issue(0, OP_SUB, 16'h06, 0, 16'hFF, 0, 16'h05, 0, 1, 0);
    issue(0, OP_AND, 16'h0F, 0, 16'h05, 0, 16'h05, 0, 1, 0);
    issue(0, OP_OR,  16'h30, 0, 16'h35, 0, 16'h05, 0, 1, 0);
    issue(0, OP_XOR, 16'hFF, 0, 16'hFA, 0, 16'h05, 0, 1, 0);
    issue(0, OP_AC,  16'h77, 0, 16'h05, 0, 16'h05, 0, 1, 0);
    issue(0, OP_NEG, 16'h00, 0, 16'hFB, 0, 16'h05, 1, 1, 0);
    issue(0, 4'd12,  16'hFF, 1, 16'h00, 0, 16'h00, 0, 1, 0);
    issue(0, OP_NEG, 16'h00, 1, 16'h00, 0, 16'h00, 0, 1, 0);

    // Shifts
    issue(0, OP_BUS, 16'h81, 1, 16'h81, 0, 16'h81, 0, 1, 0);
    issue(0, OP_SAR, 16'h03, 0, 16'hF0, 0, 16'h81, 0, 4, 0);
    issue(0, OP_SAR, 16'h00, 0, 16'h81, 0, 16'h81, 0, 1, 0);
    issue(0, OP_SHR, 16'h01, 0, 16'h40, 0, 16'h81, 1, 2, 0);
    issue(0, OP_SHL, 16'h01, 0, 16'h02, 0, 16'h81, 1, 2, 0);
    issue(0, OP_SHL, 16'h07, 1, 16'h80, 0, 16'h80, 0, 8, 0);

    // Multiply, including START held high while BUSY
    issue(0, OP_BUS, 16'hFF, 1, 16'hFF, 0,     16'hFF, 0, 1, 0);
    issue(0, OP_MUL, 16'hFF, 0, 16'h01, 16'hFE, 16'hFF, 1, 9, 1);
    issue(0, OP_BUS, 16'h0F, 1, 16'h0F, 0,     16'h0F, 0, 1, 0);
    issue(0, OP_MUL, 16'h11, 0, 16'hFF, 16'h00, 16'h0F, 0, 9, 0);
    issue(0, OP_BUS, 16'h10, 1, 16'h10, 0,     16'h10, 0, 1, 0);
    issue(0, OP_MUL, 16'h10, 1, 16'h00, 16'h01, 16'h00, 1, 9, 0);

    // Reset in the middle of a multiply: no writeback, outputs at reset values at once
    issue(0, OP_BUS, 16'h12, 1, 16'h12, 0, 16'h12, 0, 1, 0);
    drive(0, 1'b1, OP_MUL, 16'h34, 1'b1);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ac",     if8.ac,        0);
    check("abort_result", if8.result,    0);
    check("abort_hi",     if8.result_hi, 0);
    check("abort_c",      if8.c,         0);
    check("abort_z",      if8.z,         1);
    check("abort_busy",   if8.busy,      0);
    check("abort_done",   if8.done,      0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, OP_BUS, 16'h5A, 0, 16'h5A, 0, 16'h00, 0, 1, 0);

    // WIDTH=16 regression
    issue(1, OP_BUS, 16'h8001, 1, 16'h8001, 0,       16'h8001, 0, 1,  0);
    issue(1, OP_SHL, 16'h000F, 0, 16'h8000, 0,       16'h8001, 0, 16, 0);
    issue(1, OP_SHR, 16'h00F0, 0, 16'h8001, 0,       16'h8001, 0, 1,  0);
    issue(1, OP_BUS, 16'h0001, 1, 16'h0001, 0,       16'h0001, 0, 1,  0);
    issue(1, OP_NEG, 16'h0000, 0, 16'hFFFF, 0,       16'h0001, 1, 1,  0);
    issue(1, OP_BUS, 16'hFFFF, 1, 16'hFFFF, 0,       16'hFFFF, 0, 1,  0);
    issue(1, OP_MUL, 16'hFFFF, 0, 16'h0001, 16'hFFFE, 16'hFFFF, 1, 17, 0);

    repeat (2) @(negedge clk);
    check("w8_sb_empty",  q8.size(),  0);
    check("w16_sb_empty", q16.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
